baud_frac_gen: RTL

BAUD_FRAC_GEN -- requirements
Module: baud_frac_gen

---
 rtl/baud_frac_gen_pkg.sv | 28 ++
 rtl/baud_frac_gen_if.sv | 32 +++
 rtl/baud_bit_timer.sv | 89 ++++++++
 rtl/baud_frac_gen.sv | 117 +++++++++++
 4 files changed

// File: rtl/baud_frac_gen_pkg.sv
// Shared constants for the fractional baud generator.
// Holds the reset-time configuration, the per-frame trim encodings and the
// round-up / round-down period selector encoding.
package baud_frac_gen_pkg;

  // Active configuration after reset
  localparam int unsigned DefPeriod   = 20;
  localparam int unsigned DefUpNum    = 10;
  localparam int unsigned DefDownNum  = 5;
  localparam int unsigned DefFrameLen = 10;

  // Per-frame trim applied to the last period of the last bit of a frame
  typedef enum logic [1:0] {
    AdjNone    = 2'b00,
    AdjPlus    = 2'b01,
    AdjMinus   = 2'b10,
    AdjNoneAlt = 2'b11
  } byte_adj_e;

  localparam byte_adj_e DefByteAdj = AdjNone;

  // Which kind of acquisition period is currently being timed
  typedef enum logic {
    SelDown = 1'b0,
    SelUp   = 1'b1
  } period_sel_e;

endpackage

// File: rtl/baud_frac_gen_if.sv
// Control, configuration and pulse bundle of the fractional baud generator.
// master: the controller driving run/sync/config and observing the pulses.
// slave : the generator itself.
interface baud_frac_gen_if #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COMP_W   = 4,
  parameter int unsigned FRAME_W  = 4
);
  logic                Enable_i;
  logic                Sync_i;
  logic                CfgValid_i;
  logic [PERIOD_W-1:0] AcqPeriod_i;
  logic [COMP_W-1:0]   UpNum_i;
  logic [COMP_W-1:0]   DownNum_i;
  logic [FRAME_W-1:0]  FrameLen_i;
  logic [1:0]          ByteAdj_i;
  logic                AcqSig_o;
  logic                BaudSig_o;
  logic                FrameSig_o;
  logic [FRAME_W-1:0]  BitIdx_o;
  logic                CfgPending_o;

  modport master (
    output Enable_i, Sync_i, CfgValid_i, AcqPeriod_i, UpNum_i, DownNum_i, FrameLen_i, ByteAdj_i,
    input  AcqSig_o, BaudSig_o, FrameSig_o, BitIdx_o, CfgPending_o
  );

  modport slave (
    input  Enable_i, Sync_i, CfgValid_i, AcqPeriod_i, UpNum_i, DownNum_i, FrameLen_i, ByteAdj_i,
    output AcqSig_o, BaudSig_o, FrameSig_o, BitIdx_o, CfgPending_o
  );
endinterface

// File: rtl/baud_bit_timer.sv
// Times one bit as a sequence of acquisition periods of P or P+1 clocks.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   reload_i      restart the bit: period counter to 0, up/down counts reloaded
//   period_i      base period P (values below 2 behave as 2)
//   up_num_i      round-up periods per bit, used on reload and at bit end
//   down_num_i    round-down periods per bit, used on reload and at bit end
//   adj_i         trim for the final period of a frame
//   last_bit_i    current bit is the last one of the frame
//   period_end_o  current clock is the last clock of a period
//   bit_end_o     current clock ends the last period of the bit
module baud_bit_timer
  import baud_frac_gen_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COMP_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reload_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [COMP_W-1:0]   up_num_i,
  input  logic [COMP_W-1:0]   down_num_i,
  input  byte_adj_e           adj_i,
  input  logic                last_bit_i,
  output logic                period_end_o,
  output logic                bit_end_o
);
  localparam int unsigned LenW = PERIOD_W + 1;
  localparam int unsigned SumW = COMP_W + 1;

  logic [LenW-1:0]   cnt_q, cnt_d;
  logic [LenW-1:0]   p_eff, len;
  logic [COMP_W-1:0] up_q, up_d, down_q, down_d;
  logic [SumW-1:0]   left_sum;
  logic              last_period;
  period_sel_e       sel;

  // Period length and end detection; kept apart from the next-state logic so
  // the reload values never feed back into the end strobes.
  always_comb begin
    sel         = (up_q > down_q && up_q != '0) ? SelUp : SelDown;
    left_sum    = {1'b0, up_q} + {1'b0, down_q};
    last_period = (left_sum == SumW'(1));
    p_eff       = (period_i < PERIOD_W'(2)) ? LenW'(2) : LenW'(period_i);
    len         = p_eff + LenW'(sel == SelUp);
    if (last_period && last_bit_i) begin
      case (adj_i)
        AdjPlus:  len = len + LenW'(1);
        AdjMinus: len = len - LenW'(1);
        default:  ;
      endcase
    end
    period_end_o = !reload_i && (cnt_q >= len - LenW'(1));
    bit_end_o    = period_end_o && last_period;
  end

  always_comb begin
    cnt_d  = cnt_q + LenW'(1);
    up_d   = up_q;
    down_d = down_q;
    if (reload_i || bit_end_o) begin
      cnt_d  = '0;
      up_d   = up_num_i;
      // An empty bit still needs one round-down period
      down_d = (up_num_i == '0 && down_num_i == '0) ? COMP_W'(1) : down_num_i;
    end else if (period_end_o) begin
      cnt_d = '0;
      if (sel == SelUp) begin
        up_d = up_q - COMP_W'(1);
      end else begin
        down_d = down_q - COMP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      up_q   <= COMP_W'(DefUpNum);
      down_q <= COMP_W'(DefDownNum);
    end else begin
      cnt_q  <= cnt_d;
      up_q   <= up_d;
      down_q <= down_d;
    end
  end

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional baud generator: bits built from P / P+1 clock acquisition
// periods, grouped into frames, with a shadowed configuration that is
// applied only at frame end, on sync, or while stopped.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   bus       run/sync/config inputs and acquisition/bit/frame pulse outputs
module baud_frac_gen
  import baud_frac_gen_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COMP_W   = 4,
  parameter int unsigned FRAME_W  = 4
) (
  input logic           clk,
  input logic           rst,
  baud_frac_gen_if.slave bus
);
  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [COMP_W-1:0]   up_num;
    logic [COMP_W-1:0]   down_num;
    logic [FRAME_W-1:0]  frame_len;
    byte_adj_e           byte_adj;
  } cfg_t;

  localparam cfg_t CfgReset = '{
    period:    PERIOD_W'(DefPeriod),
    up_num:    COMP_W'(DefUpNum),
    down_num:  COMP_W'(DefDownNum),
    frame_len: FRAME_W'(DefFrameLen),
    byte_adj:  DefByteAdj
  };

  cfg_t               act_q, act_d, sh_q, sh_d, cfg_in, cfg_nxt;
  logic               pend_q, pend_d;
  logic [FRAME_W-1:0] bit_idx_q, bit_idx_d, flen_eff;
  logic               acq_q, acq_d, baud_q, baud_d, frame_q, frame_d;
  logic               hold, last_bit, period_end, bit_end, frame_end, apply;

  always_comb begin
    // Stopped or resyncing: timing sits at the start of a fresh bit
    hold     = !bus.Enable_i || bus.Sync_i;
    flen_eff = (act_q.frame_len == '0) ? FRAME_W'(1) : act_q.frame_len;
    last_bit = (bit_idx_q >= flen_eff - FRAME_W'(1));
  end

  baud_bit_timer #(
    .PERIOD_W (PERIOD_W),
    .COMP_W   (COMP_W)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .reload_i     (hold),
    .period_i     (act_q.period),
    .up_num_i     (cfg_nxt.up_num),
    .down_num_i   (cfg_nxt.down_num),
    .adj_i        (act_q.byte_adj),
    .last_bit_i   (last_bit),
    .period_end_o (period_end),
    .bit_end_o    (bit_end)
  );

  always_comb begin
    cfg_in = '{
      period:    bus.AcqPeriod_i,
      up_num:    bus.UpNum_i,
      down_num:  bus.DownNum_i,
      frame_len: bus.FrameLen_i,
      byte_adj:  byte_adj_e'(bus.ByteAdj_i)
    };
    frame_end = bit_end && last_bit;
    apply     = hold || frame_end;
    sh_d      = bus.CfgValid_i ? cfg_in : sh_q;
    // A strobe landing on an apply event bypasses the shadow
    cfg_nxt   = apply ? sh_d : act_q;
    act_d     = cfg_nxt;
    pend_d    = apply ? 1'b0 : (bus.CfgValid_i || pend_q);

    bit_idx_d = bit_idx_q;
    if (hold) begin
      bit_idx_d = '0;
    end else if (bit_end) begin
      bit_idx_d = last_bit ? '0 : bit_idx_q + FRAME_W'(1);
    end

    acq_d   = period_end;
    baud_d  = bit_end;
    frame_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q     <= CfgReset;
      sh_q      <= CfgReset;
      pend_q    <= 1'b0;
      bit_idx_q <= '0;
      acq_q     <= 1'b0;
      baud_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      act_q     <= act_d;
      sh_q      <= sh_d;
      pend_q    <= pend_d;
      bit_idx_q <= bit_idx_d;
      acq_q     <= acq_d;
      baud_q    <= baud_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.AcqSig_o     = acq_q;
  assign bus.BaudSig_o    = baud_q;
  assign bus.FrameSig_o   = frame_q;
  assign bus.BitIdx_o     = bit_idx_q;
  assign bus.CfgPending_o = pend_q;

endmodule
